// File: rtl/tpm_buf_pkg.sv
// Shared types and sizes for the TPM buffer byte-port arbiter.
// Byte port: AW=11 address bits, DW=8 data bits, BUF_BYTES=2048.
package tpm_buf_pkg;

  localparam int AW        = 11;
  localparam int DW        = 8;
  localparam int BUF_BYTES = 2048;

  typedef enum logic {
    REQ_H = 1'b0,
    REQ_C = 1'b1
  } req_e;

  typedef enum logic {
    ST_IDLE,
    ST_WIPE
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a registered last-grant pointer.
// Ports: clk, rst_n, req[1:0], en -> one-hot gnt[1:0].
module rr_arb2
  import tpm_buf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  req_e last_q;
  logic pick_c;

  // C wins when alone, or on contention when H was granted last.
  assign pick_c = req[1] & (~req[0] | (last_q == REQ_H));

  always_comb begin
    gnt = 2'b00;
    if (en && |req) begin
      gnt = pick_c ? 2'b10 : 2'b01;
    end
  end

  // Reset value makes H the winner of the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_C;
    end else if (|gnt) begin
      last_q <= gnt[1] ? REQ_C : REQ_H;
    end
  end

endmodule

// File: rtl/tpm_buf_port_arbiter.sv
// Shares the 2048x8 buffer byte port between host (h_*) and core (c_*).
// Ports: h/c req/we/addr/wdata/ack/rdata, ram_* byte port, zeroize_i/busy/
// zeroize_done. Buffer wipe built only with macro TPM_BUF_ZEROIZE_EN.
module tpm_buf_port_arbiter
  import tpm_buf_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_ack,
  output logic [DW-1:0] h_rdata,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata,
  input  logic          zeroize_i,
  output logic          busy,
  output logic          zeroize_done
);

  logic [1:0]    elig;
  logic [1:0]    gnt;
  logic          arb_en;
  logic          wiping;
  logic          wipe_start;
  logic [AW-1:0] wcnt_q;
  logic [AW-1:0] addr_q;

`ifdef TPM_BUF_ZEROIZE_EN
  state_e        state_q, state_d;
  logic [AW-1:0] wcnt_d;
  logic          done_q, done_d;

  assign wiping       = (state_q == ST_WIPE);
  assign wipe_start   = (state_q == ST_IDLE) && zeroize_i;
  assign busy         = wiping;
  assign zeroize_done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (zeroize_i) begin
          state_d = ST_WIPE;
          wcnt_d  = '0;
        end
      end
      ST_WIPE: begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == AW'(BUF_BYTES - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
`else
  logic unused_zeroize;

  assign unused_zeroize = zeroize_i;
  assign wiping         = 1'b0;
  assign wipe_start     = 1'b0;
  assign wcnt_q         = '0;
  assign busy           = 1'b0;
  assign zeroize_done   = 1'b0;
`endif

  // A requester is not eligible in its own ack cycle.
  assign elig   = {c_req & ~c_ack, h_req & ~h_ack};
  // The zeroize cycle already holds off requests.
  assign arb_en = ~wiping & ~wipe_start;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (elig),
    .en    (arb_en),
    .gnt   (gnt)
  );

  always_comb begin
    ram_addr  = addr_q;
    ram_wdata = '0;
    ram_we    = 1'b0;
    unique case (1'b1)
      wiping: begin
        ram_addr = wcnt_q;
        ram_we   = 1'b1;
      end
      gnt[0]: begin
        ram_addr  = h_addr;
        ram_wdata = h_wdata;
        ram_we    = h_we;
      end
      gnt[1]: begin
        ram_addr  = c_addr;
        ram_wdata = c_wdata;
        ram_we    = c_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_ack  <= 1'b0;
      c_ack  <= 1'b0;
      addr_q <= '0;
    end else begin
      h_ack  <= gnt[0];
      c_ack  <= gnt[1];
      addr_q <= ram_addr;
    end
  end

  // RAM read data arrives in the ack cycle; pass it only to the acked side.
  assign h_rdata = h_ack ? ram_rdata : '0;
  assign c_rdata = c_ack ? ram_rdata : '0;

endmodule

// File: tb/tb_tpm_buf_port_arbiter.sv
// Scoreboard bench for tpm_buf_port_arbiter with a 2048x8 RAM model.
// Zeroize checks follow macro TPM_BUF_ZEROIZE_EN.
`timescale 1ns/1ps
module tb_tpm_buf_port_arbiter;

  typedef struct {
    logic       we;
    logic [7:0] rd;
    int         edge_no;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        h_req, h_we, c_req, c_we;
  logic [10:0] h_addr, c_addr, ram_addr;
  logic [7:0]  h_wdata, c_wdata, h_rdata, c_rdata;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        h_ack, c_ack, ram_we;
  logic        zeroize_i, busy, zeroize_done;

  logic [7:0]  mem [2048];
  exp_t        hq[$];
  exp_t        cq[$];
  int          checks   = 0;
  int          failures = 0;
  int          edge_n   = 0;
  logic        h_req_prev, c_req_prev;

  tpm_buf_port_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .h_req        (h_req),
    .h_we         (h_we),
    .h_addr       (h_addr),
    .h_wdata      (h_wdata),
    .h_ack        (h_ack),
    .h_rdata      (h_rdata),
    .c_req        (c_req),
    .c_we         (c_we),
    .c_addr       (c_addr),
    .c_wdata      (c_wdata),
    .c_ack        (c_ack),
    .c_rdata      (c_rdata),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_rdata    (ram_rdata),
    .zeroize_i    (zeroize_i),
    .busy         (busy),
    .zeroize_done (zeroize_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] iv(int a);
    return 8'(a * 7 + 3);
  endfunction

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata  <= mem[ram_addr];
    edge_n     <= edge_n + 1;
    h_req_prev <= h_req;
    c_req_prev <= c_req;
  end

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (h_ack) begin
      assert (h_req_prev) else $error("FAIL h_proto ack without request");
      checks++;
      if (hq.size() == 0) begin
        failures++;
        $display("FAIL h_ack unexpected at edge %0d", edge_n);
      end else begin
        e = hq.pop_front();
        if (e.edge_no != edge_n || (!e.we && h_rdata != e.rd)) begin
          failures++;
          $display("FAIL h_ack edge=%0d need=%0d rdata=%02h need=%02h",
                   edge_n, e.edge_no, h_rdata, e.rd);
        end
      end
    end
    if (c_ack) begin
      assert (c_req_prev) else $error("FAIL c_proto ack without request");
      checks++;
      if (cq.size() == 0) begin
        failures++;
        $display("FAIL c_ack unexpected at edge %0d", edge_n);
      end else begin
        e = cq.pop_front();
        if (e.edge_no != edge_n || (!e.we && c_rdata != e.rd)) begin
          failures++;
          $display("FAIL c_ack edge=%0d need=%0d rdata=%02h need=%02h",
                   edge_n, e.edge_no, c_rdata, e.rd);
        end
      end
    end
  end

  task automatic chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s got=%0h need=%0h", nm, act, req);
    end
  endtask

  task automatic h_op(logic we, logic [10:0] a, logic [7:0] wd,
                      logic [7:0] rd);
    @(negedge clk);
    h_req = 1'b1; h_we = we; h_addr = a; h_wdata = wd;
    hq.push_back('{we, rd, edge_n + 1});
    @(negedge clk);
    h_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int bad;
    for (int i = 0; i < 2048; i++) mem[i] = iv(i);
    rst_n = 1'b0; zeroize_i = 1'b0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_acks", {30'd0, h_ack, c_ack}, 0);
    chk("rst_rdata", {16'd0, h_rdata, c_rdata}, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_busy_done", {30'd0, busy, zeroize_done}, 0);
    rst_n = 1'b1;

    // Contending readers alternate H,C,H,C from reset
    @(negedge clk);
    e = edge_n;
    h_req = 1'b1; h_we = 1'b0; h_addr = 11'h020;
    c_req = 1'b1; c_we = 1'b0; c_addr = 11'h021;
    for (int k = 0; k < 4; k++) begin
      hq.push_back('{1'b0, iv('h20), e + 1 + 2 * k});
      cq.push_back('{1'b0, iv('h21), e + 2 + 2 * k});
    end
    repeat (8) @(negedge clk);
    h_req = 1'b0; c_req = 1'b0;

    // After a lone H grant, contention goes to C first
    h_op(1'b0, 11'h022, 8'h00, iv('h22));
    @(negedge clk);
    e = edge_n;
    h_req = 1'b1; h_addr = 11'h020;
    c_req = 1'b1; c_addr = 11'h021;
    cq.push_back('{1'b0, iv('h21), e + 1});
    hq.push_back('{1'b0, iv('h20), e + 2});
    repeat (2) @(negedge clk);
    h_req = 1'b0; c_req = 1'b0;

    // Host write then read back
    h_op(1'b1, 11'h010, 8'hA5, 8'h00);
    h_op(1'b0, 11'h010, 8'h00, 8'hA5);

    // Core writes top address, host reads it one cycle later
    @(negedge clk);
    e = edge_n;
    c_req = 1'b1; c_we = 1'b1; c_addr = 11'h7FF; c_wdata = 8'h3C;
    cq.push_back('{1'b1, 8'h00, e + 1});
    @(negedge clk);
    c_req = 1'b0; c_we = 1'b0;
    h_req = 1'b1; h_we = 1'b0; h_addr = 11'h7FF;
    hq.push_back('{1'b0, 8'h3C, e + 2});
    @(negedge clk);
    h_req = 1'b0;

    // Reset right after a write issue: ack is lost
    @(negedge clk);
    h_req = 1'b1; h_we = 1'b1; h_addr = 11'h030; h_wdata = 8'h55;
    @(posedge clk);
    #1;
    rst_n = 1'b0; h_req = 1'b0; h_we = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (h_ack || c_ack || ram_we) bad++;
    end
    chk("reset_mid_access", bad, 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (h_ack || c_ack || ram_we) bad++;
    end
    chk("after_reset_quiet", bad, 0);

`ifdef TPM_BUF_ZEROIZE_EN
    for (int i = 0; i < 16; i++) h_op(1'b1, 11'(i), 8'hFF, 8'h00);
    @(negedge clk);
    e = edge_n;
    zeroize_i = 1'b1;
    h_req = 1'b1; h_we = 1'b0; h_addr = 11'h005;
    hq.push_back('{1'b0, 8'h00, e + 2050});
    @(negedge clk);
    zeroize_i = 1'b0;
    bad = 0;
    for (int k = 1; k <= 2048; k++) begin
      if (!busy || zeroize_done || h_ack) bad++;
      zeroize_i = (k == 1000);
      @(negedge clk);
    end
    zeroize_i = 1'b0;
    chk("wipe_busy_window", bad, 0);
    chk("wipe_end_busy", busy, 0);
    chk("wipe_done_pulse", zeroize_done, 1);
    @(negedge clk);
    h_req = 1'b0;
    chk("wipe_done_single", zeroize_done, 0);
    for (int i = 0; i < 16; i++) h_op(1'b0, 11'(i), 8'h00, 8'h00);
    h_op(1'b0, 11'h7FF, 8'h00, 8'h00);
`else
    @(negedge clk);
    zeroize_i = 1'b1;
    @(negedge clk);
    zeroize_i = 1'b0;
    bad = 0;
    repeat (5) begin
      if (busy || zeroize_done) bad++;
      @(negedge clk);
    end
    chk("zeroize_ignored", bad, 0);
    h_op(1'b0, 11'h010, 8'h00, 8'hA5);
    h_op(1'b0, 11'h7FF, 8'h00, 8'h3C);
`endif

    repeat (3) @(negedge clk);
    chk("h_queue_drained", hq.size(), 0);
    chk("c_queue_drained", cq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
